// File: rtl/shift_pkg.sv
// Shared definitions for the iterative barrel-shifter front end:
// op codes, FSM state encoding and width helpers.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SLA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [2:0] {
    SH_SLL  = OP_SLL,
    SH_SRL  = OP_SRL,
    SH_SRA  = OP_SRA,
    SH_SLA  = OP_SLA,
    SH_ROL  = OP_ROL,
    SH_ROR  = OP_ROR,
    SH_RSV6 = 3'b110,
    SH_RSV7 = 3'b111
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

  // Shift-amount width for an N-bit operand (N is a power of two, >= 2).
  function automatic int shift_amt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_mask_gen.sv
// Combinational decode of (op, amt) into fill mask, SLA/SRA flags, legality and
// rotate direction. ROL/ROR are legal only when SHIFT_ROTATE_EN is defined.
module shift_mask_gen
  import shift_pkg::*;
#(
  parameter int N = 8,
  localparam int S = shift_amt_w(N)
) (
  input  logic [2:0]   op,
  input  logic [S-1:0] amt,
  output logic [N-1:0] p_msk,
  output logic         sla,
  output logic         sra,
  output logic         illegal,
  output logic         left
);

  localparam logic [N-1:0] ONES = '1;

  always_comb begin
    p_msk   = ONES;
    sla     = 1'b0;
    sra     = 1'b0;
    illegal = 1'b0;
    left    = 1'b0;
    case (op)
      OP_SLL: begin
        p_msk = ONES << amt;
        left  = 1'b1;
      end
      OP_SRL: p_msk = ONES >> amt;
      OP_SRA: begin
        p_msk = ONES >> amt;
        sra   = 1'b1;
      end
      OP_SLA: begin
        p_msk = ONES << amt;
        sla   = 1'b1;
        left  = 1'b1;
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROL: left = 1'b1;
      OP_ROR: left = 1'b0;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_issue.sv
// Barrel-shifter front end: accepts one request, rotates it right one log2 stage per
// cycle (S cycles, fixed), then holds the result until consumed. Macro: SHIFT_ROTATE_EN.
module shift_issue
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [shift_amt_w(N)-1:0]  in_amt,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               Y_hat,
  output logic [N-1:0]               P_msk,
  output logic                       sla,
  output logic                       sra,
  output logic [N-1:0]               A,
  output logic                       illegal
);

  localparam int S = shift_amt_w(N);
  localparam logic [S-1:0] LAST_STAGE = S'(S - 1);

  shift_state_t state_q, state_d;
  logic [S-1:0] cnt_q;
  logic [S-1:0] r_q, r_d;
  logic [S-1:0] step;
  logic [2*N-1:0] dbl;
  logic [N-1:0] y_rot;

  logic [N-1:0] m_p_msk;
  logic         m_sla, m_sra, m_ill, m_left;

  shift_mask_gen #(.N(N)) u_mask (
    .op      (in_op),
    .amt     (in_amt),
    .p_msk   (m_p_msk),
    .sla     (m_sla),
    .sra     (m_sra),
    .illegal (m_ill),
    .left    (m_left)
  );

  // Left shifts become right rotates by the S-bit two's complement of the amount.
  always_comb begin
    r_d = in_amt;
    if (m_ill)
      r_d = '0;
    else if (m_left)
      r_d = S'(N) - in_amt;
  end

  always_comb begin
    step  = S'(1) << cnt_q;
    dbl   = {Y_hat, Y_hat} >> step;
    y_rot = dbl[N-1:0];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_STAGE) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      Y_hat   <= '0;
      A       <= '0;
      P_msk   <= '0;
      sla     <= 1'b0;
      sra     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_valid && in_ready) begin
        cnt_q   <= '0;
        r_q     <= r_d;
        Y_hat   <= in_a;
        A       <= in_a;
        P_msk   <= m_p_msk;
        sla     <= m_sla;
        sra     <= m_sra;
        illegal <= m_ill;
      end else if (state_q == ST_SHIFT) begin
        cnt_q <= cnt_q + S'(1);
        if (|(r_q & step)) Y_hat <= y_rot;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue (N=8): directed vector table, handshake/reset sequences and
// randomized requests against a rotate/mask reference model.
module tb_shift_issue;
  import shift_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [2:0] in_amt = 3'd0;
  logic [2:0] in_op = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Y_hat, P_msk, A;
  logic       sla, sra, illegal;

  int n_cmp = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  shift_issue #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y_hat     (Y_hat),
    .P_msk     (P_msk),
    .sla       (sla),
    .sra       (sra),
    .A         (A),
    .illegal   (illegal)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [2:0] amt;
    logic [7:0] y;
    logic [7:0] p;
    logic       s_la;
    logic       s_ra;
    logic       ill;
    int         hold;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    int v;
    v = int'(x);
    return 8'(((v << k) | (v >> (8 - k))) & 255);
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
    int v;
    v = int'(x);
    return 8'(((v >> k) | (v << (8 - k))) & 255);
  endfunction

  // Reference: what a shift/rotate by amt should produce, independent of stage order.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [2:0] amt,
                       output logic [7:0] y, output logic [7:0] p,
                       output logic s_la, output logic s_ra, output logic ill);
    int k;
    bit rot_en;
`ifdef SHIFT_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    k = int'(amt);
    y = a; p = 8'hFF; s_la = 1'b0; s_ra = 1'b0; ill = 1'b0;
    case (op)
      3'd0: begin y = rotl(a, k); p = 8'((255 << k) & 255); end
      3'd1: begin y = rotr(a, k); p = 8'(255 >> k); end
      3'd2: begin y = rotr(a, k); p = 8'(255 >> k); s_ra = 1'b1; end
      3'd3: begin y = rotl(a, k); p = 8'((255 << k) & 255); s_la = 1'b1; end
      3'd4: if (rot_en) y = rotl(a, k); else ill = 1'b1;
      3'd5: if (rot_en) y = rotr(a, k); else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endtask

  task automatic check_txn(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [2:0] amt, input int hold,
                           input logic [7:0] ey, input logic [7:0] ep,
                           input logic es_la, input logic es_ra, input logic eill);
    int w;
    int lat;
    logic [7:0] y0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_op = op; in_a = a; in_amt = amt; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " Y_hat"}, 32'(Y_hat), 32'(ey));
    chk({tag, " P_msk"}, 32'(P_msk), 32'(ep));
    chk({tag, " A"}, 32'(A), 32'(a));
    chk({tag, " flags"}, 32'({sla, sra, illegal}), 32'({es_la, es_ra, eill}));
    y0 = Y_hat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, 32'({out_valid, in_ready, Y_hat}), 32'({1'b1, 1'b0, y0}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drop"}, 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
    chk({tag, " kept"}, 32'(Y_hat), 32'(y0));
  endtask

  initial begin
    logic [7:0] y, p;
    logic s1, s2, il;
    logic [2:0] op, amt;
    logic [7:0] a;
    int seen;

    tbl[0]  = '{3'd1, 8'hB4, 3'd3, 8'h96, 8'h1F, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{3'd0, 8'h81, 3'd1, 8'h03, 8'hFE, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{3'd0, 8'h81, 3'd0, 8'h81, 8'hFF, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{3'd2, 8'h80, 3'd7, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 2};
    tbl[4]  = '{3'd3, 8'h40, 3'd2, 8'h01, 8'hFC, 1'b1, 1'b0, 1'b0, 0};
`ifdef SHIFT_ROTATE_EN
    tbl[5]  = '{3'd4, 8'h0F, 3'd4, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{3'd5, 8'h01, 3'd1, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
`else
    tbl[5]  = '{3'd4, 8'h0F, 3'd4, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
    tbl[6]  = '{3'd5, 8'h01, 3'd1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1};
`endif
    tbl[7]  = '{3'd7, 8'h5A, 3'd3, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{3'd6, 8'hC3, 3'd5, 8'hC3, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
    tbl[9]  = '{3'd1, 8'hFF, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{3'd3, 8'h12, 3'd0, 8'h12, 8'hFF, 1'b1, 1'b0, 1'b0, 0};

    repeat (2) @(negedge clk);
    chk("reset ctl", 32'({in_ready, out_valid}), 32'({1'b1, 1'b0}));
    chk("reset data", 32'({Y_hat, P_msk, A, sla, sra, illegal}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      check_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].amt, tbl[i].hold,
                tbl[i].y, tbl[i].p, tbl[i].s_la, tbl[i].s_ra, tbl[i].ill);

    // Stalled DONE with a competing request: it must wait for the handshake.
    @(negedge clk);
    in_op = 3'd1; in_a = 8'hB4; in_amt = 3'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall valid", 32'(out_valid), 32'd1);
    in_op = 3'd0; in_a = 8'h81; in_amt = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall hold", 32'({out_valid, in_ready, Y_hat, P_msk, A}),
          32'({1'b1, 1'b0, 8'h96, 8'h1F, 8'hB4}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall release", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
    @(negedge clk);
    in_valid = 1'b0;
    chk("next accepted", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("next result", 32'({out_valid, Y_hat, P_msk, A}), 32'({1'b1, 8'h03, 8'hFE, 8'h81}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of SHIFT discards the request.
    @(negedge clk);
    in_op = 3'd2; in_a = 8'h80; in_amt = 3'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ctl", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
    chk("midrst data", 32'({Y_hat, P_msk, A, sla, sra, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no stale", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 8'($urandom_range(0, 255));
      amt = 3'($urandom_range(0, 7));
      model(op, a, amt, y, p, s1, s2, il);
      check_txn($sformatf("rnd%0d", i), op, a, amt, int'($urandom_range(0, 2)),
                y, p, s1, s2, il);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
